// File: rtl/cache_msg_pkg.sv
// Shared cache message encodings, default widths and field layout.
// Messages are packed MSB-first: request {type,opaque,addr,len,data},
// response {type,opaque,len,data}; data always sits at bit 0.
package cache_msg_pkg;

    localparam logic [1:0] MSG_READ  = 2'd0;
    localparam logic [1:0] MSG_WRITE = 2'd1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OPQ_W  = 8;

    function automatic int req_w(input int opq_w, input int addr_w,
                                 input int data_w);
        return 4 + opq_w + addr_w + data_w;
    endfunction

    function automatic int rsp_w(input int opq_w, input int data_w);
        return 4 + opq_w + data_w;
    endfunction

    function automatic int req_addr_lsb(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int req_opq_lsb(input int addr_w, input int data_w);
        return data_w + 2 + addr_w;
    endfunction

    function automatic int req_type_lsb(input int opq_w, input int addr_w,
                                        input int data_w);
        return data_w + 2 + addr_w + opq_w;
    endfunction

    function automatic int rsp_opq_lsb(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int rsp_type_lsb(input int opq_w, input int data_w);
        return data_w + 2 + opq_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECONF,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } tg_state_e;

endpackage

// File: rtl/cache_req_traffic_gen_if.sv
// Cache request/response valid-ready bus between generator and cache.
// master: drives requests, accepts responses; slave: the cache side.
interface cache_req_traffic_gen_if
    import cache_msg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OPQ_W  = DEF_OPQ_W
);

    localparam int REQ_W = req_w(OPQ_W, ADDR_W, DATA_W);
    localparam int RSP_W = rsp_w(OPQ_W, DATA_W);

    logic [REQ_W-1:0] cachereq_msg;
    logic             cachereq_val;
    logic             cachereq_rdy;
    logic [RSP_W-1:0] cacheresp_msg;
    logic             cacheresp_val;
    logic             cacheresp_rdy;

    modport master (
        output cachereq_msg, cachereq_val,
        input  cachereq_rdy,
        input  cacheresp_msg, cacheresp_val,
        output cacheresp_rdy
    );

    modport slave (
        input  cachereq_msg, cachereq_val,
        output cachereq_rdy,
        output cacheresp_msg, cacheresp_val,
        input  cacheresp_rdy
    );

endinterface

// File: rtl/cache_resp_checker.sv
// Compares an accepted cache response against the expected type/opaque
// (and data on reads). Ports: resp_fire/resp_msg in, exp_* in, err out.
module cache_resp_checker
    import cache_msg_pkg::*;
#(
    parameter int OPQ_W  = DEF_OPQ_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int RSP_W = rsp_w(OPQ_W, DATA_W)
) (
    input  logic              resp_fire,
    input  logic [RSP_W-1:0]  resp_msg,
    input  logic [1:0]        exp_type,
    input  logic [OPQ_W-1:0]  exp_opq,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              chk_data,
    output logic              err
);

    localparam int TYPE_LSB = rsp_type_lsb(OPQ_W, DATA_W);
    localparam int OPQ_LSB  = rsp_opq_lsb(DATA_W);

    logic [1:0]        rsp_type;
    logic [OPQ_W-1:0]  rsp_opq;
    logic [DATA_W-1:0] rsp_data;
    logic              unused_len;

    assign rsp_type   = resp_msg[TYPE_LSB +: 2];
    assign rsp_opq    = resp_msg[OPQ_LSB +: OPQ_W];
    assign rsp_data   = resp_msg[0 +: DATA_W];
    assign unused_len = ^resp_msg[DATA_W +: 2];

    // One pulse per accepted response, however many fields disagree.
    assign err = resp_fire &&
                 ((rsp_type != exp_type) ||
                  (rsp_opq != exp_opq) ||
                  (chk_data && (rsp_data != exp_data)));

endmodule

// File: rtl/cache_req_traffic_gen.sv
// Cache traffic generator: applies a cache mode, issues NUM_REQ writes
// then NUM_REQ reads of a strided pattern and counts response mismatches.
// Ports: clk, reset (sync, high), start, cfg_mode -> reconfiguration,
// bus (master side of cache_req_traffic_gen_if), busy/done/timeout,
// err_cnt. Define CACHE_TRAFFIC_TIMEOUT_EN to add the response watchdog.
module cache_req_traffic_gen
    import cache_msg_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                OPQ_W       = DEF_OPQ_W,
    parameter int                NUM_REQ     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(32'h100),
    parameter logic [DATA_W-1:0] DATA_SEED   = DATA_W'(32'h0a0b0c0d),
    parameter logic [DATA_W-1:0] DATA_STEP   = DATA_W'(32'h04040404),
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cfg_mode,
    output logic [1:0] reconfiguration,
    cache_req_traffic_gen_if.master bus,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [15:0] err_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    tg_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [OPQ_W-1:0]  cur_opq;
    logic              is_rd, in_resp;
    logic              req_val, resp_rdy;
    logic              req_fire, resp_fire;
    logic              start_ok, chk_err, tmo_hit;

    // Request fields are a pure function of state and idx, so the message
    // cannot move while a request is stalled.
    assign cur_addr = BASE_ADDR + ADDR_W'(idx_q) * ADDR_STRIDE;
    assign cur_data = DATA_SEED + DATA_W'(idx_q) * DATA_STEP;
    assign cur_opq  = OPQ_W'(idx_q);
    assign is_rd    = (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
    assign in_resp  = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);

    assign bus.cachereq_msg = {is_rd ? MSG_READ : MSG_WRITE, cur_opq,
                               cur_addr, 2'b00,
                               is_rd ? {DATA_W{1'b0}} : cur_data};
    assign bus.cachereq_val  = req_val;
    assign bus.cacheresp_rdy = resp_rdy;

    assign req_fire  = req_val && bus.cachereq_rdy;
    assign resp_fire = resp_rdy && bus.cacheresp_val;
    assign start_ok  = start &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign done      = (state_q == ST_DONE);

    cache_resp_checker #(
        .OPQ_W  (OPQ_W),
        .DATA_W (DATA_W)
    ) u_chk (
        .resp_fire (resp_fire),
        .resp_msg  (bus.cacheresp_msg),
        .exp_type  (is_rd ? MSG_READ : MSG_WRITE),
        .exp_opq   (cur_opq),
        .exp_data  (cur_data),
        .chk_data  (is_rd),
        .err       (chk_err)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RECONF;
                    idx_d   = '0;
                end
            end
            ST_RECONF: begin
                busy    = 1'b1;
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                busy    = 1'b1;
                req_val = 1'b1;
                if (bus.cachereq_rdy) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                busy     = 1'b1;
                resp_rdy = 1'b1;
                if (bus.cacheresp_val) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WR_REQ;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                busy    = 1'b1;
                req_val = 1'b1;
                if (bus.cachereq_rdy) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                busy     = 1'b1;
                resp_rdy = 1'b1;
                if (bus.cacheresp_val) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            reconfiguration <= 2'b00;
            err_cnt         <= 16'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (start_ok) begin
                reconfiguration <= cfg_mode;
                err_cnt         <= 16'h0;
            end else if ((chk_err || tmo_hit) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'h1;
            end
        end
    end

`ifdef CACHE_TRAFFIC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    // A response arriving on the last watchdog cycle still wins.
    assign tmo_hit = in_resp && !bus.cacheresp_val &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (req_fire) begin
                tmo_cnt_q <= '0;
            end else if (in_resp && !tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (start_ok) begin
                timeout_q <= 1'b0;
            end else if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    logic          unused_sig;

    assign tmo_hit    = 1'b0;
    assign timeout    = 1'b0;
    assign unused_sig = req_fire ^ in_resp;
`endif

endmodule

// File: tb/tb_cache_req_traffic_gen.sv
// Directed bench for cache_req_traffic_gen: ideal memory model on the
// slave side, request scoreboard, stall/corrupt/reset/timeout scenarios.
`timescale 1ns/1ps
module tb_cache_req_traffic_gen;
    import cache_msg_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int OPQ_W   = 8;
    localparam int NUM_REQ = 3;
    localparam int REQ_W   = 4 + OPQ_W + ADDR_W + DATA_W;
    localparam int RSP_W   = 4 + OPQ_W + DATA_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [1:0]  reconfiguration;
    logic        busy, done, timeout;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    cache_req_traffic_gen_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .OPQ_W  (OPQ_W)
    ) bus ();

    cache_req_traffic_gen #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .OPQ_W       (OPQ_W),
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_mode        (cfg_mode),
        .reconfiguration (reconfiguration),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .err_cnt         (err_cnt)
    );

    int tests = 0;
    int fails = 0;

    logic [REQ_W-1:0]  sb[$];
    logic [DATA_W-1:0] mem[logic [ADDR_W-1:0]];
    logic [REQ_W-1:0]  last_req = '0;
    logic [RSP_W-1:0]  pend_msg;
    bit stall_w1 = 0, corrupt_rd2 = 0, hold_reads = 0, no_resp = 0;
    bit req_take = 0, resp_take = 0, pend = 0;
    int stall_seen = 0;
    int fires = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] exp_req(input bit rd, input int i);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [1:0]        t;
        a = 32'h0 + 32'(i) * 32'h100;
        d = rd ? 32'h0 : 32'h0a0b0c0d + 32'(i) * 32'h04040404;
        t = rd ? 2'd0 : 2'd1;
        return {t, 8'(i), a, 2'b00, d};
    endfunction

    task automatic push_all();
        for (int i = 0; i < NUM_REQ; i++) sb.push_back(exp_req(1'b0, i));
        for (int i = 0; i < NUM_REQ; i++) sb.push_back(exp_req(1'b1, i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] mode);
        push_all();
        cfg_mode = mode;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("reconf_state", {busy, bus.cachereq_val, done}, 3'b100);
        tick();
        chk("wr_req_val", bus.cachereq_val, 1'b1);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) tick();
        chk("done_reached", done, 1'b1);
    endtask

    // Memory model: drives slave inputs on the falling edge so the DUT
    // samples stable values; handshakes are resolved here for the next
    // rising edge.
    always @(negedge clk) begin
        if (reset) begin
            bus.cachereq_rdy  = 1'b0;
            bus.cacheresp_val = 1'b0;
            bus.cacheresp_msg = '0;
            req_take  = 0;
            resp_take = 0;
            pend      = 0;
        end else begin
            if (resp_take) begin
                bus.cacheresp_val = 1'b0;
                resp_take = 0;
            end
            if (req_take) begin
                logic [1:0]        t;
                logic [7:0]        o;
                logic [ADDR_W-1:0] a;
                logic [DATA_W-1:0] d;
                req_take = 0;
                t = last_req[75:74];
                o = last_req[73:66];
                a = last_req[65:34];
                if (t == 2'd1) begin
                    mem[a]   = last_req[31:0];
                    pend_msg = {2'd1, o, 2'b00, 32'h0};
                end else begin
                    d = mem.exists(a) ? mem[a] : 32'h0;
                    if (corrupt_rd2 && o == 8'd2) d = 32'h0;
                    pend_msg = {2'd0, o, 2'b00, d};
                end
                pend = !(no_resp || (hold_reads && t == 2'd0));
            end
            if (pend) begin
                bus.cacheresp_val = 1'b1;
                bus.cacheresp_msg = pend_msg;
                pend = 0;
            end
            bus.cachereq_rdy = 1'b1;
            if (bus.cachereq_val && stall_w1 && stall_seen < 5 &&
                bus.cachereq_msg[75:74] == 2'd1 &&
                bus.cachereq_msg[73:66] == 8'd1) begin
                bus.cachereq_rdy = 1'b0;
                stall_seen++;
                if (sb.size() != 0) chk("stall_msg", bus.cachereq_msg, sb[0]);
            end
            if (bus.cachereq_val && bus.cachereq_rdy) begin
                req_take = 1;
                fires++;
                last_req = bus.cachereq_msg;
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) chk("req_msg", bus.cachereq_msg, sb.pop_front());
            end
            resp_take = bus.cacheresp_val && bus.cacheresp_rdy;
        end
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cfg_mode = 2'd0;
        repeat (3) tick();
        chk("rst_reconf", reconfiguration, 2'd0);
        chk("rst_val_rdy", {bus.cachereq_val, bus.cacheresp_rdy}, 2'b00);
        chk("rst_flags", {busy, done, timeout}, 3'b000);
        chk("rst_err", err_cnt, 16'h0);
        reset = 1'b0;
        tick();
        chk("idle_resp_rdy", bus.cacheresp_rdy, 1'b0);

        // Basic run; a start pulse while busy must be ignored.
        fires = 0;
        run(2'd1);
        cfg_mode = 2'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(400);
        chk("t1_err", err_cnt, 16'h0);
        chk("t1_reconf", reconfiguration, 2'd1);
        chk("t1_busy", busy, 1'b0);
        chk("t1_fires", fires, 6);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_mem0", mem[32'h000], 32'h0a0b0c0d);
        chk("t1_mem1", mem[32'h100], 32'h0e0f1011);
        chk("t1_mem2", mem[32'h200], 32'h12131415);
        chk("t1_done_rdy", {bus.cachereq_val, bus.cacheresp_rdy}, 2'b00);

        // Request stall on write 1.
        fires      = 0;
        stall_seen = 0;
        stall_w1   = 1;
        run(2'd2);
        wait_done(400);
        stall_w1 = 0;
        chk("t2_stalls", stall_seen, 5);
        chk("t2_fires", fires, 6);
        chk("t2_err", err_cnt, 16'h0);
        chk("t2_reconf", reconfiguration, 2'd2);

        // Corrupted read 2.
        corrupt_rd2 = 1;
        run(2'd3);
        wait_done(400);
        corrupt_rd2 = 0;
        chk("t3_err", err_cnt, 16'h1);
        chk("t3_sb_empty", sb.size(), 0);

        // Reset while waiting for a read response.
        hold_reads = 1;
        fires = 0;
        run(2'd1);
        chk("t4_err_clr", err_cnt, 16'h0);
        for (int i = 0; i < 200 &&
             !(bus.cacheresp_rdy && last_req[75:74] == 2'd0 && fires > 0); i++)
            tick();
        chk("t4_in_rd_resp", bus.cacheresp_rdy && last_req[75:74] == 2'd0, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        chk("t4_rst_outs", {reconfiguration, bus.cachereq_val,
                            bus.cacheresp_rdy, busy, done, timeout}, 7'b0);
        chk("t4_rst_err", err_cnt, 16'h0);
        sb.delete();
        hold_reads = 0;
        reset = 1'b0;
        tick();
        fires = 0;
        run(2'd2);
        wait_done(400);
        chk("t4_fires", fires, 6);
        chk("t4_err", err_cnt, 16'h0);
        chk("t4_sb_empty", sb.size(), 0);

`ifdef CACHE_TRAFFIC_TIMEOUT_EN
        begin
            int c;
            no_resp = 1;
            fires = 0;
            run(2'd1);
            for (int i = 0; i < 100 && fires == 0; i++) tick();
            c = 0;
            while (!timeout && c < 100) begin
                tick();
                c++;
            end
            chk("t5_tmo_cycles", c, 16);
            chk("t5_tmo", timeout, 1'b1);
            chk("t5_err", err_cnt, 16'h1);
            chk("t5_done", done, 1'b1);
            sb.delete();
            no_resp = 0;
            run(2'd1);
            chk("t5_tmo_clr", timeout, 1'b0);
            wait_done(400);
            chk("t5_err2", err_cnt, 16'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
